// File: rtl/qam_symbol_scheduler.sv
// Frames a byte stream into 16-QAM symbols: alternating preamble, then payload nibbles
// (high first), each symbol held for SAMPLES_PER_SYMBOL mapper samples.
module qam_symbol_scheduler #(
  parameter int SAMPLES_PER_SYMBOL = 8,
  parameter int PREAMBLE_SYMBOLS   = 16
) (
  input  logic        ipClk,
  input  logic        ipReset,
  input  logic        ipTxStart,
  input  logic [15:0] ipTxLength,
  input  logic [7:0]  ipData,
  input  logic        ipDataValid,
  output logic        opDataReady,
  output logic [3:0]  opQAMStream,
  output logic        opQAMValid,
  output logic        opSymbolStrobe,
  output logic        opBusy,
  output logic        opDone,
  output logic        opUnderflow
);

  localparam int SW = $clog2(SAMPLES_PER_SYMBOL);
  localparam logic [SW-1:0] SAMP_LAST = SW'(SAMPLES_PER_SYMBOL - 1);
  localparam logic [16:0] PRE_LAST = 17'((PREAMBLE_SYMBOLS > 0) ? PREAMBLE_SYMBOLS - 1 : 0);
  localparam logic [3:0] PRE_EVEN = 4'b0101;
  localparam logic [3:0] PRE_ODD  = 4'b1010;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    STALL
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] samp_q, samp_d;
  logic [16:0]   sym_q, sym_d;
  logic [15:0]   fetched_q, fetched_d;
  logic [15:0]   len_q, len_d;
  logic [7:0]    h_q, h_d;
  logic          h_full_q, h_full_d;
  logic [3:0]    s_q, s_d;
  logic          hi_q, hi_d;
  logic [3:0]    stream_q, stream_d;
  logic          valid_q, valid_d;
  logic          strobe_q, strobe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          underflow_q, underflow_d;

  logic          xfer;
  logic          boundary;
  logic          need_byte;
  logic [7:0]    resume_byte;
  logic [16:0]   last_data_sym;

  assign opDataReady = !h_full_q && (fetched_q < len_q) && (state_q != IDLE);
  assign xfer        = ipDataValid && opDataReady;
  assign boundary    = (samp_q == SAMP_LAST);
  assign last_data_sym = {len_q, 1'b0} - 17'd1;
  assign resume_byte = h_full_q ? h_q : ipData;

  always_comb begin
    state_d     = state_q;
    samp_d      = samp_q;
    sym_d       = sym_q;
    fetched_d   = fetched_q;
    len_d       = len_q;
    h_d         = h_q;
    h_full_d    = h_full_q;
    s_d         = s_q;
    hi_d        = hi_q;
    stream_d    = stream_q;
    valid_d     = valid_q;
    strobe_d    = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    underflow_d = underflow_q;
    need_byte   = 1'b0;

    // A byte accepted while stalled bypasses H and goes straight into S below
    if (xfer) begin
      fetched_d = fetched_q + 16'd1;
      if (state_q != STALL) begin
        h_d      = ipData;
        h_full_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (ipTxStart && (ipTxLength != 16'd0)) begin
          len_d       = ipTxLength;
          fetched_d   = 16'd0;
          h_full_d    = 1'b0;
          sym_d       = 17'd0;
          samp_d      = '0;
          hi_d        = 1'b0;
          underflow_d = 1'b0;
          busy_d      = 1'b1;
          if (PREAMBLE_SYMBOLS > 0) begin
            state_d  = PREAMBLE;
            stream_d = PRE_EVEN;
            valid_d  = 1'b1;
            strobe_d = 1'b1;
          end else begin
            // Without a preamble there is no time to prefetch: wait for the first byte
            state_d = STALL;
            valid_d = 1'b0;
          end
        end
      end

      PREAMBLE: begin
        samp_d = boundary ? '0 : samp_q + SW'(1);
        if (boundary) begin
          if (sym_q != PRE_LAST) begin
            sym_d    = sym_q + 17'd1;
            stream_d = sym_q[0] ? PRE_EVEN : PRE_ODD;
            strobe_d = 1'b1;
          end else begin
            sym_d     = 17'd0;
            need_byte = 1'b1;
          end
        end
      end

      DATA: begin
        samp_d = boundary ? '0 : samp_q + SW'(1);
        if (boundary) begin
          if (sym_q == last_data_sym) begin
            state_d  = IDLE;
            valid_d  = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            stream_d = 4'h0;
            hi_d     = 1'b0;
          end else if (hi_q) begin
            sym_d    = sym_q + 17'd1;
            stream_d = s_q;
            hi_d     = 1'b0;
            strobe_d = 1'b1;
          end else begin
            sym_d     = sym_q + 17'd1;
            need_byte = 1'b1;
          end
        end
      end

      STALL: begin
        if (h_full_q || xfer) begin
          state_d  = DATA;
          s_d      = resume_byte[3:0];
          stream_d = resume_byte[7:4];
          hi_d     = 1'b1;
          valid_d  = 1'b1;
          strobe_d = 1'b1;
          samp_d   = '0;
          h_full_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase

    // sym_d already points at the symbol being started, so a stall resumes at the same index
    if (need_byte) begin
      if (h_full_q) begin
        state_d  = DATA;
        s_d      = h_q[3:0];
        stream_d = h_q[7:4];
        hi_d     = 1'b1;
        strobe_d = 1'b1;
        h_full_d = 1'b0;
      end else begin
        state_d     = STALL;
        valid_d     = 1'b0;
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      state_q     <= IDLE;
      samp_q      <= '0;
      sym_q       <= 17'd0;
      fetched_q   <= 16'd0;
      len_q       <= 16'd0;
      h_q         <= 8'h00;
      h_full_q    <= 1'b0;
      s_q         <= 4'h0;
      hi_q        <= 1'b0;
      stream_q    <= 4'h0;
      valid_q     <= 1'b0;
      strobe_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      samp_q      <= samp_d;
      sym_q       <= sym_d;
      fetched_q   <= fetched_d;
      len_q       <= len_d;
      h_q         <= h_d;
      h_full_q    <= h_full_d;
      s_q         <= s_d;
      hi_q        <= hi_d;
      stream_q    <= stream_d;
      valid_q     <= valid_d;
      strobe_q    <= strobe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      underflow_q <= underflow_d;
    end
  end

  assign opQAMStream    = stream_q;
  assign opQAMValid     = valid_q;
  assign opSymbolStrobe = strobe_q;
  assign opBusy         = busy_q;
  assign opDone         = done_q;
  assign opUnderflow    = underflow_q;

endmodule
